ma_mem_seq: RTL and testbench
=============================

# ma_mem_seq

Parametrised memory-cycle sequencer for the PDP-8/e core. It replaces fixed single-cycle RAM access with a command/response engine in front of a variable-latency memory port. It executes fetch, read, write, auto-index defer and ISZ read-modify-write cycles across a configurable number of 4K fields. Nonexistent fields read as 0000 and ignore writes. It sits between the major-state controller and main memory.

## Interface
- FIELD_W, 3, width of field number; memory address is FIELD_W+12 bits
- MAX_FIELD, 1, highest implemented field; must be < 2**FIELD_W
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready at rising edge
- cmd_op  in  3  0 FETCH, 1 READ, 2 WRITE, 3 DEFER, 4 ISZ; 5-7 treated as READ
- cmd_field  in  FIELD_W  field (IF or DF, chosen by controller)
- cmd_addr  in  12  word address within field
- cmd_wdata  in  12  write data (WRITE only)
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_data  out  12  read data (FETCH/READ), effective address (DEFER), incremented value (ISZ), echoed write data (WRITE)
- rsp_skip  out  1  valid with rsp_valid; ISZ result wrapped to 0000
- instruction  out  12  last fetched instruction
- mem_req  out  1  memory cycle request, held until mem_ack
- mem_we  out  1  write qualifier, stable while mem_req
- mem_addr  out  FIELD_W+12  {field, address}, stable while mem_req
- mem_wdata  out  12  write data, stable while mem_req
- mem_ack  in  1  memory done; read data valid in the same cycle
- mem_rdata  in  12  read data

## Operation
- States: IDLE, RD, MOD, WR, RSP. cmd_ready = 1 only in IDLE with reset deasserted.
- On accept: latch op, field, addr and wdata. Compute nx = (field > MAX_FIELD).
- Next state: WRITE goes to WR. All other ops go to RD.
- RD: mem_req=1, mem_we=0. On mem_ack, latch mem_rdata into data register.
  - If nx: skip the memory cycle and load data=0000 without asserting mem_req.
  - FETCH/READ then go to RSP. DEFER/ISZ then go to MOD.
- MOD (one cycle): DEFER with addr[0:8]==9'o001 (0010-0017): data = data+1 mod 4096, go to WR. Other DEFER: go to RSP. ISZ: skip = (data==7777), data = data+1 mod 4096, go to WR.
- WR: mem_req=1, mem_we=1, mem_wdata = data (cmd_wdata for WRITE). Leave on mem_ack. If nx: no mem_req, leave next cycle.
- RSP: rsp_valid=1 for one cycle with rsp_data=data and rsp_skip=skip. FETCH also loads instruction<=data. Then go to IDLE.
- rsp_skip is 0 for every op except ISZ.
- All arithmetic is 12-bit modulo; 7777+1 = 0000.
- mem_addr = {field, addr} from the latched command, never from live cmd_* inputs.

## Timing
- Reset asserted: state=IDLE, cmd_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0000, rsp_skip=0, instruction=7000. Effect is immediate, not clocked.
- Reset asserted mid-cycle: mem_req drops at once. A pending write is abandoned. No rsp_valid is produced.
- Zero-wait memory (mem_ack high on first request cycle), cycles counted after the accept edge:
  - FETCH/READ: RD, RSP. rsp_valid in the 2nd cycle, cmd_ready again in the 3rd.
  - WRITE: WR, RSP. Same timing as READ.
  - DEFER without auto-index: RD, MOD, RSP. rsp_valid in the 3rd cycle.
  - Auto-index DEFER / ISZ: RD, MOD, WR, RSP. rsp_valid in the 4th cycle.
- Each wait state (mem_ack low) adds one cycle. mem_req, mem_we, mem_addr and mem_wdata hold unchanged across waits.
- Nonexistent field: same cycle counts as zero-wait, with mem_req never asserted.
- cmd_valid while busy is ignored; the controller must hold it until accepted.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Reset release, then FETCH field 0 addr 0200 (mem holds 1234, zero-wait):
  - mem_req with mem_addr=0_0200 in cycle 1; rsp_valid in cycle 2 with rsp_data=1234.
  - instruction goes 7000 -> 1234. cmd_ready back in cycle 3.
- DEFER field 0 addr 0012 (mem=0377): one read then a write of 0400 to 0_0012; rsp_data=0400.
- DEFER addr 0020 (mem=0377): no write; rsp_data=0377.
- ISZ addr 0100, mem=7777, 3 wait states per access: write of 0000; rsp_skip=1; rsp_valid in cycle 10.
- ISZ with mem=0005: write 0006, rsp_skip=0.
- MAX_FIELD=1, WRITE field 2: mem_req stays 0 throughout; rsp_valid in cycle 2.
- MAX_FIELD=1, READ field 2: rsp_data=0000.
- MAX_FIELD=1, FETCH field 3: instruction=0000.
- Assert reset during a WR wait state: mem_req drops in the same cycle; no rsp_valid.
- Same case after release: IDLE, cmd_ready=1, instruction=7000.

Source files
------------

// File: rtl/ma_mem_seq_if.sv
// ma_mem_seq_if -- bundle of the signals between the memory-cycle sequencer,
// the major-state controller (command/response side) and main memory.
//
// Signals:
//   cmd_valid/cmd_ready   command handshake from the controller
//   cmd_op/field/addr/wdata  command payload
//   rsp_valid/data/skip   one-cycle completion pulse with result
//   instruction           last fetched instruction word
//   mem_req/we/addr/wdata memory cycle request, held until mem_ack
//   mem_ack/mem_rdata     memory completion, read data valid with ack
//
// Modports: slave = sequencer, master = controller plus memory side.
`timescale 1ns/1ps
interface ma_mem_seq_if #(
    parameter int FIELD_W = 3
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [FIELD_W-1:0]   cmd_field;
    logic [11:0]          cmd_addr;
    logic [11:0]          cmd_wdata;
    logic                 rsp_valid;
    logic [11:0]          rsp_data;
    logic                 rsp_skip;
    logic [11:0]          instruction;
    logic                 mem_req;
    logic                 mem_we;
    logic [FIELD_W+11:0]  mem_addr;
    logic [11:0]          mem_wdata;
    logic                 mem_ack;
    logic [11:0]          mem_rdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_field, cmd_addr, cmd_wdata,
        input  mem_ack, mem_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_skip, instruction,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_field, cmd_addr, cmd_wdata,
        output mem_ack, mem_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_skip, instruction,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ma_mem_seq.sv
// ma_mem_seq -- PDP-8/e memory-cycle sequencer. Accepts one command at a
// time (FETCH, READ, WRITE, DEFER, ISZ) and runs the needed read and/or
// write cycles against a variable-latency memory port, then pulses a
// response. Fields above MAX_FIELD do not exist: they read as 0000, ignore
// writes and never raise mem_req, but keep the zero-wait cycle timing.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    ma_mem_seq_if.slave (command, response and memory signals)
`timescale 1ns/1ps
module ma_mem_seq #(
    parameter int FIELD_W   = 3,
    parameter int MAX_FIELD = 1
) (
    input  logic            clk,
    input  logic            reset,
    ma_mem_seq_if.slave     bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MOD  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    localparam logic [2:0] OP_FETCH = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_DEFER = 3'd3;
    localparam logic [2:0] OP_ISZ   = 3'd4;

    localparam logic [FIELD_W-1:0] MAX_F = FIELD_W'(MAX_FIELD);

    logic [2:0]         state;
    logic [2:0]         op;
    logic [FIELD_W-1:0] field;
    logic [11:0]        addr;
    logic               nx;
    logic [11:0]        data;
    logic               skip;
    logic [11:0]        instr;

    // 12-bit modulo increment: 7777 + 1 wraps to 0000.
    function automatic logic [11:0] inc12(input logic [11:0] v);
        return v + 12'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op    <= OP_FETCH;
            field <= '0;
            addr  <= '0;
            nx    <= 1'b0;
            data  <= 12'o0000;
            skip  <= 1'b0;
            instr <= 12'o7000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        // Unused opcodes 5-7 behave as READ.
                        op    <= (bus.cmd_op > OP_ISZ) ? OP_READ : bus.cmd_op;
                        field <= bus.cmd_field;
                        addr  <= bus.cmd_addr;
                        nx    <= (bus.cmd_field > MAX_F);
                        // Preloading wdata lets WR always drive mem_wdata
                        // from the data register; reads overwrite it in RD.
                        data  <= bus.cmd_wdata;
                        skip  <= 1'b0;
                        state <= (bus.cmd_op == OP_WRITE) ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    if (nx || bus.mem_ack) begin
                        data  <= nx ? 12'o0000 : bus.mem_rdata;
                        state <= (op == OP_FETCH || op == OP_READ) ? S_RSP : S_MOD;
                    end
                end
                S_MOD: begin
                    if (op == OP_ISZ) begin
                        skip  <= (data == 12'o7777);
                        data  <= inc12(data);
                        state <= S_WR;
                    end else if (addr[11:3] == 9'o001) begin
                        // Auto-index locations 0010-0017 are bumped before use.
                        data  <= inc12(data);
                        state <= S_WR;
                    end else begin
                        state <= S_RSP;
                    end
                end
                S_WR: begin
                    if (nx || bus.mem_ack) begin
                        state <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (op == OP_FETCH) begin
                        instr <= data;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Combinational from state so that reset removes the request at once.
    assign bus.cmd_ready   = reset && (state == S_IDLE);
    assign bus.mem_req     = (state == S_RD || state == S_WR) && !nx;
    assign bus.mem_we      = (state == S_WR);
    assign bus.mem_addr    = {field, addr};
    assign bus.mem_wdata   = data;
    assign bus.rsp_valid   = (state == S_RSP);
    assign bus.rsp_data    = data;
    assign bus.rsp_skip    = skip;
    assign bus.instruction = instr;
endmodule

// File: tb/tb_ma_mem_seq.sv
// Testbench for ma_mem_seq: directed commands against a behavioural memory
// with programmable wait states. Expected responses and memory accesses are
// queued when a command is issued; monitors pop and compare them.
`timescale 1ns/1ps
module tb_ma_mem_seq;
    localparam int FW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ma_mem_seq_if #(.FIELD_W(FW)) bus();
    ma_mem_seq #(.FIELD_W(FW), .MAX_FIELD(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] data;
        logic        skip;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [14:0] addr;
        logic        we;
        logic [11:0] data;
    } acc_t;

    rsp_t rq[$];
    acc_t aq[$];
    logic [11:0] mem [0:32767];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int waits = 0;
    int wcnt  = 0;
    bit nx_mode = 1'b0;

    logic        prev_hold = 1'b0;
    logic [14:0] prev_addr;
    logic        prev_we;
    logic [11:0] prev_wd;
    rsp_t        r;
    acc_t        a;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model and monitors, all sampled on the falling edge.
    always @(negedge clk) begin
        if (reset && bus.mem_req && prev_hold) begin
            check("mem_addr hold", int'(bus.mem_addr), int'(prev_addr));
            check("mem_we hold", int'(bus.mem_we), int'(prev_we));
            check("mem_wdata hold", int'(bus.mem_wdata), int'(prev_wd));
        end
        if (nx_mode) check("nx mem_req", int'(bus.mem_req), 0);
        prev_hold = 1'b0;
        if (!bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end else if (wcnt >= waits) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr];
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            check("mem access expected", int'(aq.size() > 0), 1);
            if (aq.size() > 0) begin
                a = aq.pop_front();
                check("mem_addr", int'(bus.mem_addr), int'(a.addr));
                check("mem_we", int'(bus.mem_we), int'(a.we));
                if (a.we) check("mem_wdata", int'(bus.mem_wdata), int'(a.data));
            end
            wcnt = 0;
        end else begin
            bus.mem_ack = 1'b0;
            wcnt++;
            prev_hold = 1'b1;
            prev_addr = bus.mem_addr;
            prev_we   = bus.mem_we;
            prev_wd   = bus.mem_wdata;
        end
        if (bus.rsp_valid) begin
            check("rsp expected", int'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                check("rsp_data", int'(bus.rsp_data), int'(r.data));
                check("rsp_skip", int'(bus.rsp_skip), int'(r.skip));
                check("rsp latency", cyc - r.acc + 1, r.lat);
            end
        end
    end

    task automatic exp_acc(input logic [14:0] ad, input logic we, input logic [11:0] d);
        acc_t e;
        e.addr = ad; e.we = we; e.data = d;
        aq.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] f, input logic [11:0] ad,
                         input logic [11:0] wd, input bit want, input logic [11:0] ed,
                         input logic es, input int lat);
        rsp_t e;
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready before issue", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_field = f;
        bus.cmd_addr  = ad;
        bus.cmd_wdata = wd;
        if (want) begin
            e.data = ed; e.skip = es; e.acc = cyc + 1; e.lat = lat;
            rq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_field = '0;
        bus.cmd_addr  = 12'o0000;
        bus.cmd_wdata = 12'o0000;
    endtask

    task automatic wait_done();
        int n = 0;
        while (rq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("response arrived", rq.size(), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_field = '0;
        bus.cmd_addr  = 12'o0000;
        bus.cmd_wdata = 12'o0000;
        for (int i = 0; i < 32768; i++) mem[i] = 12'o0000;
        mem[15'o00200] = 12'o1234;
        mem[15'o00012] = 12'o0377;
        mem[15'o00020] = 12'o0377;
        mem[15'o00100] = 12'o7777;
        mem[15'o00101] = 12'o0005;
        mem[15'o10040] = 12'o2525;

        repeat (2) @(posedge clk);
        #1;
        check("reset cmd_ready", int'(bus.cmd_ready), 0);
        check("reset mem_req", int'(bus.mem_req), 0);
        check("reset mem_addr", int'(bus.mem_addr), 0);
        check("reset rsp_valid", int'(bus.rsp_valid), 0);
        check("reset rsp_data", int'(bus.rsp_data), 0);
        check("reset instruction", int'(bus.instruction), 'o7000);
        @(negedge clk);
        reset = 1'b1;

        // FETCH 0_0200, zero-wait
        waits = 0;
        exp_acc(15'o00200, 1'b0, 12'o0);
        issue(3'd0, 3'd0, 12'o0200, 12'o0, 1'b1, 12'o1234, 1'b0, 2);
        wait_done();
        check("fetch cmd_ready cycle 3", int'(bus.cmd_ready), 1);
        check("fetch instruction", int'(bus.instruction), 'o1234);

        // Auto-index DEFER 0012
        exp_acc(15'o00012, 1'b0, 12'o0);
        exp_acc(15'o00012, 1'b1, 12'o0400);
        issue(3'd3, 3'd0, 12'o0012, 12'o0, 1'b1, 12'o0400, 1'b0, 4);
        wait_done();

        // Plain DEFER 0020
        exp_acc(15'o00020, 1'b0, 12'o0);
        issue(3'd3, 3'd0, 12'o0020, 12'o0, 1'b1, 12'o0377, 1'b0, 3);
        wait_done();

        // ISZ wrap with 3 wait states per access
        waits = 3;
        exp_acc(15'o00100, 1'b0, 12'o0);
        exp_acc(15'o00100, 1'b1, 12'o0000);
        issue(3'd4, 3'd0, 12'o0100, 12'o0, 1'b1, 12'o0000, 1'b1, 10);
        wait_done();

        // ISZ no wrap
        waits = 0;
        exp_acc(15'o00101, 1'b0, 12'o0);
        exp_acc(15'o00101, 1'b1, 12'o0006);
        issue(3'd4, 3'd0, 12'o0101, 12'o0, 1'b1, 12'o0006, 1'b0, 4);
        wait_done();

        // Nonexistent fields
        nx_mode = 1'b1;
        issue(3'd2, 3'd2, 12'o0050, 12'o1111, 1'b1, 12'o1111, 1'b0, 2);
        wait_done();
        issue(3'd1, 3'd2, 12'o0200, 12'o0, 1'b1, 12'o0000, 1'b0, 2);
        wait_done();
        issue(3'd0, 3'd3, 12'o0200, 12'o0, 1'b1, 12'o0000, 1'b0, 2);
        wait_done();
        nx_mode = 1'b0;
        check("nx fetch instruction", int'(bus.instruction), 0);

        // Opcode 7 behaves as READ, field 1, one wait state
        waits = 1;
        exp_acc(15'o10040, 1'b0, 12'o0);
        issue(3'd7, 3'd1, 12'o0040, 12'o0, 1'b1, 12'o2525, 1'b0, 3);
        wait_done();

        // WRITE field 1, two wait states
        waits = 2;
        exp_acc(15'o10041, 1'b1, 12'o6543);
        issue(3'd2, 3'd1, 12'o0041, 12'o6543, 1'b1, 12'o6543, 1'b0, 4);
        wait_done();
        check("write landed", int'(mem[15'o10041]), 'o6543);

        // Reset during a WR wait state
        waits = 5;
        issue(3'd2, 3'd0, 12'o0300, 12'o4444, 1'b0, 12'o0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wr req before reset", int'(bus.mem_req), 1);
        check("wr we before reset", int'(bus.mem_we), 1);
        reset = 1'b0;
        #1;
        check("async reset mem_req", int'(bus.mem_req), 0);
        check("async reset mem_we", int'(bus.mem_we), 0);
        check("async reset mem_addr", int'(bus.mem_addr), 0);
        check("async reset mem_wdata", int'(bus.mem_wdata), 0);
        check("async reset cmd_ready", int'(bus.cmd_ready), 0);
        check("async reset rsp_valid", int'(bus.rsp_valid), 0);
        check("async reset rsp_skip", int'(bus.rsp_skip), 0);
        check("async reset instruction", int'(bus.instruction), 'o7000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post reset cmd_ready", int'(bus.cmd_ready), 1);
        check("post reset instruction", int'(bus.instruction), 'o7000);
        check("post reset mem_req", int'(bus.mem_req), 0);
        repeat (8) @(posedge clk);
        #1;
        check("abandoned write", int'(mem[15'o00300]), 0);
        check("leftover accesses", aq.size(), 0);
        check("leftover responses", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end
endmodule
